// File: rtl/nios_system_avalon_st_ready_latency_tx_adapter.sv
// Source-side Avalon-ST timing adapter: buffers a readyLatency=0 stream in a
// small FIFO and issues beats only in cycles a readyLatency=N sink has granted.
module nios_system_avalon_st_ready_latency_tx_adapter #(
   parameter int DATA_WIDTH    = 32,
   parameter int CHANNEL_WIDTH = 2,
   parameter int ERROR_WIDTH   = 6,
   parameter int READY_LATENCY = 2,
   parameter int DEPTH         = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   output logic                         in_ready,
   input  logic                         in_valid,
   input  logic [DATA_WIDTH-1:0]        in_data,
   input  logic [CHANNEL_WIDTH-1:0]     in_channel,
   input  logic [ERROR_WIDTH-1:0]       in_error,
   input  logic                         in_startofpacket,
   input  logic                         in_endofpacket,
   input  logic                         out_ready,
   output logic                         out_valid,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [CHANNEL_WIDTH-1:0]     out_channel,
   output logic [ERROR_WIDTH-1:0]       out_error,
   output logic                         out_startofpacket,
   output logic                         out_endofpacket,
   output logic [$clog2(DEPTH+1)-1:0]   fill_level
);

   localparam int PW = $clog2(DEPTH);
   localparam int FW = $clog2(DEPTH + 1);
   localparam int WW = DATA_WIDTH + CHANNEL_WIDTH + ERROR_WIDTH + 2;
   localparam logic [FW-1:0] FULL = FW'(DEPTH);

   logic [WW-1:0]            mem_q [DEPTH];
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]            rd_ptr_q, rd_ptr_d;
   logic [FW-1:0]            fill_q, fill_d;
   logic [READY_LATENCY-1:0] rdy_hist_q, rdy_hist_d;
   logic                     out_valid_q, out_valid_d;
   logic [WW-1:0]            out_pay_q, out_pay_d;
   logic [WW-1:0]            in_pay;
   logic                     grant;
   logic                     push;
   logic                     pop;
   logic                     unused_hist;

   assign in_pay   = {in_data, in_channel, in_error, in_startofpacket, in_endofpacket};
   // No path from out_ready: a full FIFO stays not-ready even while popping.
   assign in_ready = !reset && (fill_q < FULL);
   assign push     = in_valid && in_ready;
   assign pop      = grant && (fill_q != '0);

   // Grant for the upcoming edge comes from out_ready sampled READY_LATENCY-1 cycles earlier.
   generate
      if (READY_LATENCY == 1) begin : g_rl1
         assign grant = out_ready;
      end else begin : g_rln
         assign grant = rdy_hist_q[READY_LATENCY-2];
      end
   endgenerate

   assign unused_hist = rdy_hist_q[READY_LATENCY-1];

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      fill_d      = fill_q;
      rdy_hist_d  = READY_LATENCY'({rdy_hist_q, out_ready});
      out_valid_d = pop;
      out_pay_d   = out_pay_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d  = rd_ptr_q + PW'(1);
         out_pay_d = mem_q[rd_ptr_q];
      end
      case ({push, pop})
         2'b10:   fill_d = fill_q + FW'(1);
         2'b01:   fill_d = fill_q - FW'(1);
         default: fill_d = fill_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         fill_q      <= '0;
         rdy_hist_q  <= '0;
         out_valid_q <= 1'b0;
         out_pay_q   <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         fill_q      <= fill_d;
         rdy_hist_q  <= rdy_hist_d;
         out_valid_q <= out_valid_d;
         out_pay_q   <= out_pay_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_pay;
      end
   end

   assign out_valid = out_valid_q;
   assign {out_data, out_channel, out_error, out_startofpacket, out_endofpacket} = out_pay_q;
   assign fill_level = fill_q;

endmodule

// File: tb/tb_nios_system_avalon_st_ready_latency_tx_adapter.sv
// Bench for the Avalon-ST ready-latency TX adapter: RL=2 and RL=3 instances share
// stimulus and are checked against a queue-based reference model.
module tb_nios_system_avalon_st_ready_latency_tx_adapter;

   localparam int WW   = 42;
   localparam int LOGN = 4096;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic [31:0] in_data;
   logic [1:0]  in_channel;
   logic [5:0]  in_error;
   logic        in_sop;
   logic        in_eop;
   logic        out_ready;

   logic        in_ready2, ov2, sop2, eop2;
   logic [31:0] od2;
   logic [1:0]  oc2;
   logic [5:0]  oe2;
   logic [2:0]  fill2;
   logic        in_ready3, ov3, sop3, eop3;
   logic [31:0] od3;
   logic [1:0]  oc3;
   logic [5:0]  oe3;
   logic [2:0]  fill3;

   always #5 clk = ~clk;

   nios_system_avalon_st_ready_latency_tx_adapter #(
      .DATA_WIDTH(32), .CHANNEL_WIDTH(2), .ERROR_WIDTH(6), .READY_LATENCY(2), .DEPTH(4)
   ) dut2 (
      .clk(clk), .reset(reset), .in_ready(in_ready2), .in_valid(in_valid),
      .in_data(in_data), .in_channel(in_channel), .in_error(in_error),
      .in_startofpacket(in_sop), .in_endofpacket(in_eop), .out_ready(out_ready),
      .out_valid(ov2), .out_data(od2), .out_channel(oc2), .out_error(oe2),
      .out_startofpacket(sop2), .out_endofpacket(eop2), .fill_level(fill2)
   );

   nios_system_avalon_st_ready_latency_tx_adapter #(
      .DATA_WIDTH(32), .CHANNEL_WIDTH(2), .ERROR_WIDTH(6), .READY_LATENCY(3), .DEPTH(4)
   ) dut3 (
      .clk(clk), .reset(reset), .in_ready(in_ready3), .in_valid(in_valid),
      .in_data(in_data), .in_channel(in_channel), .in_error(in_error),
      .in_startofpacket(in_sop), .in_endofpacket(in_eop), .out_ready(out_ready),
      .out_valid(ov3), .out_data(od3), .out_channel(oc3), .out_error(oe3),
      .out_startofpacket(sop3), .out_endofpacket(eop3), .fill_level(fill3)
   );

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int last_rst = -100;
   bit mv       = 1'b0;

   bit ready_log [LOGN];
   bit ov2_log   [LOGN];
   bit ov3_log   [LOGN];

   logic [WW-1:0] q2[$];
   logic [WW-1:0] q3[$];
   logic          m_ov  [2];
   logic [WW-1:0] m_pay [2];

   typedef struct {
      logic        iv;
      logic [31:0] d;
      logic        ordy;
      logic        exp_ir;
      logic [2:0]  exp_fill;
      logic        exp_ov;
      logic [31:0] exp_od;
   } row_t;

   row_t tbl [27];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
      end
   endtask

   function automatic logic [31:0] dk(input int k);
      return 32'hA000_0000 + 32'(k);
   endfunction

   task automatic drive(input logic iv, input logic [31:0] d);
      in_valid   = iv;
      in_data    = d;
      in_channel = d[1:0];
      in_error   = d[7:2];
      in_sop     = d[8];
      in_eop     = d[9];
   endtask

   // Sink grant for the edge closing cycle t: out_ready from RL-1 cycles earlier,
   // provided that sample was taken after the most recent reset.
   function automatic bit grant_exp(input int rl, input int t);
      int idx;
      idx = t - (rl - 1);
      if (idx <= last_rst) return 1'b0;
      return ready_log[idx];
   endfunction

   task automatic model_cycle(input int k, input int rl, input logic ir_a, input logic [2:0] fl_a,
                              input logic ov_a, input logic [WW-1:0] pay_a);
      int            sz;
      int            idx;
      logic          exp_ir;
      logic [WW-1:0] head;
      logic [WW-1:0] cur;
      cur    = {in_data, in_channel, in_error, in_sop, in_eop};
      sz     = (k == 0) ? q2.size() : q3.size();
      exp_ir = !reset && (sz < 4);
      if (mv) begin
         chk($sformatf("in_ready_rl%0d", rl), 64'(ir_a), 64'(exp_ir));
         chk($sformatf("fill_rl%0d", rl), 64'(fl_a), 64'(sz));
         chk($sformatf("out_valid_rl%0d", rl), 64'(ov_a), 64'(m_ov[k]));
         chk($sformatf("payload_rl%0d", rl), 64'(pay_a), 64'(m_pay[k]));
         if (ov_a === 1'b1) begin
            idx = cyc - rl;
            chk($sformatf("grant_inv_rl%0d", rl),
                64'((idx > last_rst) && ready_log[idx]), 64'(1));
         end
      end
      if (reset) begin
         if (k == 0) q2.delete(); else q3.delete();
         m_ov[k]  = 1'b0;
         m_pay[k] = '0;
      end else begin
         if (grant_exp(rl, cyc) && sz > 0) begin
            head     = (k == 0) ? q2.pop_front() : q3.pop_front();
            m_ov[k]  = 1'b1;
            m_pay[k] = head;
         end else begin
            m_ov[k] = 1'b0;
         end
         if (in_valid && exp_ir) begin
            if (k == 0) q2.push_back(cur); else q3.push_back(cur);
         end
      end
   endtask

   task automatic cycle();
      @(negedge clk);
      if (cyc >= LOGN) begin
         $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, LOGN);
         failures++;
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $fatal(1, "cycle budget exceeded");
      end
      ready_log[cyc] = out_ready;
      model_cycle(0, 2, in_ready2, fill2, ov2, {od2, oc2, oe2, sop2, eop2});
      model_cycle(1, 3, in_ready3, fill3, ov3, {od3, oc3, oe3, sop3, eop3});
      ov2_log[cyc] = ov2;
      ov3_log[cyc] = ov3;
      if (reset) begin
         last_rst = cyc;
         mv       = 1'b1;
      end
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 32'h0);
      cycle();
      reset = 1'b0;
   endtask

   initial begin
      int t0;
      int bias;
      reset     = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 32'h0);
      m_ov[0] = 1'b0; m_ov[1] = 1'b0;
      m_pay[0] = '0;  m_pay[1] = '0;

      // RL=2 expectations: back-to-back flow, lost grant, fill to full, pop while full.
      tbl[0]  = '{1'b1, dk(0), 1'b1, 1'b1, 3'd0, 1'b0, 32'h0};
      tbl[1]  = '{1'b1, dk(1), 1'b1, 1'b1, 3'd1, 1'b0, 32'h0};
      tbl[2]  = '{1'b1, dk(2), 1'b1, 1'b1, 3'd1, 1'b1, dk(0)};
      tbl[3]  = '{1'b1, dk(3), 1'b1, 1'b1, 3'd1, 1'b1, dk(1)};
      tbl[4]  = '{1'b0, 32'h0, 1'b1, 1'b1, 3'd1, 1'b1, dk(2)};
      tbl[5]  = '{1'b0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b1, dk(3)};
      tbl[6]  = '{1'b0, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, dk(3)};
      tbl[7]  = '{1'b0, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, dk(3)};
      tbl[8]  = '{1'b0, 32'h0, 1'b1, 1'b1, 3'd0, 1'b0, dk(3)};
      tbl[9]  = '{1'b0, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, dk(3)};
      tbl[10] = '{1'b0, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, dk(3)};
      tbl[11] = '{1'b0, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, dk(3)};
      tbl[12] = '{1'b1, dk(4), 1'b0, 1'b1, 3'd0, 1'b0, dk(3)};
      tbl[13] = '{1'b1, dk(5), 1'b0, 1'b1, 3'd1, 1'b0, dk(3)};
      tbl[14] = '{1'b1, dk(6), 1'b0, 1'b1, 3'd2, 1'b0, dk(3)};
      tbl[15] = '{1'b1, dk(7), 1'b0, 1'b1, 3'd3, 1'b0, dk(3)};
      tbl[16] = '{1'b1, dk(8), 1'b0, 1'b0, 3'd4, 1'b0, dk(3)};
      tbl[17] = '{1'b1, dk(8), 1'b0, 1'b0, 3'd4, 1'b0, dk(3)};
      tbl[18] = '{1'b1, dk(8), 1'b1, 1'b0, 3'd4, 1'b0, dk(3)};
      tbl[19] = '{1'b1, dk(8), 1'b1, 1'b0, 3'd4, 1'b0, dk(3)};
      tbl[20] = '{1'b1, dk(8), 1'b1, 1'b1, 3'd3, 1'b1, dk(4)};
      tbl[21] = '{1'b1, dk(9), 1'b1, 1'b1, 3'd3, 1'b1, dk(5)};
      tbl[22] = '{1'b0, 32'h0, 1'b1, 1'b1, 3'd3, 1'b1, dk(6)};
      tbl[23] = '{1'b0, 32'h0, 1'b1, 1'b1, 3'd2, 1'b1, dk(7)};
      tbl[24] = '{1'b0, 32'h0, 1'b1, 1'b1, 3'd1, 1'b1, dk(8)};
      tbl[25] = '{1'b0, 32'h0, 1'b0, 1'b1, 3'd0, 1'b1, dk(9)};
      tbl[26] = '{1'b0, 32'h0, 1'b0, 1'b1, 3'd0, 1'b0, dk(9)};

      cycle();
      do_reset();
      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].iv, tbl[i].d);
         out_ready = tbl[i].ordy;
         #1;
         chk($sformatf("tbl%0d_in_ready", i), 64'(in_ready2), 64'(tbl[i].exp_ir));
         chk($sformatf("tbl%0d_fill", i), 64'(fill2), 64'(tbl[i].exp_fill));
         chk($sformatf("tbl%0d_out_valid", i), 64'(ov2), 64'(tbl[i].exp_ov));
         chk($sformatf("tbl%0d_out_data", i), 64'(od2), 64'(tbl[i].exp_od));
         cycle();
      end

      // Alternating sink ready with a full FIFO.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, dk(20 + i));
         cycle();
      end
      drive(1'b0, 32'h0);
      for (int i = 0; i < 3; i++) cycle();
      t0 = cyc;
      for (int r = 0; r < 12; r++) begin
         out_ready = (r < 8) && (r % 2 == 0);
         cycle();
      end
      for (int r = 0; r < 12; r++) begin
         chk($sformatf("toggle_rl3_r%0d", r), 64'(ov3_log[t0 + r]),
             64'((r >= 3) && (r <= 9) && ((r - 3) % 2 == 0)));
         chk($sformatf("toggle_rl2_r%0d", r), 64'(ov2_log[t0 + r]),
             64'((r >= 2) && (r <= 8) && (r % 2 == 0)));
      end

      // Reset with beats buffered and the sink ready.
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, dk(40 + i));
         cycle();
      end
      drive(1'b0, 32'h0);
      out_ready = 1'b1;
      reset     = 1'b1;
      #1;
      chk("rst_in_ready_rl2", 64'(in_ready2), 64'(0));
      chk("rst_in_ready_rl3", 64'(in_ready3), 64'(0));
      cycle();
      reset = 1'b0;
      drive(1'b1, dk(50));
      #1;
      chk("post_rst_ov_rl2", 64'(ov2), 64'(0));
      chk("post_rst_fill_rl2", 64'(fill2), 64'(0));
      chk("post_rst_ov_rl3", 64'(ov3), 64'(0));
      chk("post_rst_fill_rl3", 64'(fill3), 64'(0));
      t0 = cyc;
      cycle();
      drive(1'b0, 32'h0);
      for (int i = 0; i < 5; i++) cycle();
      chk("first_ov_rl2_early", 64'(ov2_log[t0 + 1]), 64'(0));
      chk("first_ov_rl2", 64'(ov2_log[t0 + 2]), 64'(1));
      chk("first_ov_rl3_early", 64'(ov3_log[t0 + 2]), 64'(0));
      chk("first_ov_rl3", 64'(ov3_log[t0 + 3]), 64'(1));

      // Randomized traffic with varying sink duty cycle and occasional resets.
      bias = 50;
      for (int i = 0; i < 2000; i++) begin
         if (i % 200 == 0) bias = int'($urandom_range(10, 95));
         reset     = ($urandom_range(0, 199) == 0);
         out_ready = (int'($urandom_range(0, 99)) < bias);
         drive($urandom_range(0, 3) != 0, $urandom);
         cycle();
      end
      reset = 1'b0;
      drive(1'b0, 32'h0);
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
